// File: rtl/alu_bist_ctrl.sv
// Built-in self-test controller for the single-cycle ALU. It sweeps every opcode over an
// LFSR operand sequence, folds each result into a MISR and compares it with a golden signature.
module alu_bist_ctrl #(
    parameter int          NUM_OPS     = 6,
    parameter int          NUM_VECTORS = 16,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] expected_sig,
    output logic [2:0]  alu_con,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [4:0]  alu_sft_amt,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature
);

    localparam int          OW        = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int          VW        = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [OW-1:0] OP_LAST = OW'(NUM_OPS - 1);
    localparam logic [VW-1:0] VEC_LAST = VW'(NUM_VECTORS - 1);
    localparam logic [31:0] SEED      = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRIVE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     lfsr_q, lfsr_d;
    logic [31:0]     misr_q, misr_d;
    logic [OW-1:0]   op_idx_q, op_idx_d;
    logic [VW-1:0]   vec_idx_q, vec_idx_d;
    logic [31:0]     exp_sig_q, exp_sig_d;
    logic [2:0]      alu_con_q, alu_con_d;
    logic [31:0]     alu_op1_q, alu_op1_d;
    logic [31:0]     alu_op2_q, alu_op2_d;
    logic [4:0]      alu_sft_amt_q, alu_sft_amt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        misr_d        = misr_q;
        op_idx_d      = op_idx_q;
        vec_idx_d     = vec_idx_q;
        exp_sig_d     = exp_sig_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        alu_con_d     = alu_con_q;
        alu_op1_d     = alu_op1_q;
        alu_op2_d     = alu_op2_q;
        alu_sft_amt_d = alu_sft_amt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    exp_sig_d = expected_sig;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            S_LOAD: begin
                state_d   = S_DRIVE;
                lfsr_d    = SEED;
                misr_d    = 32'h0;
                op_idx_d  = '0;
                vec_idx_d = '0;
            end
            S_DRIVE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                misr_d = {misr_q[30:0], 1'b0} ^ (misr_q[31] ? MISR_POLY : 32'h0) ^ alu_result;
                if (op_idx_q < OP_LAST) begin
                    op_idx_d = op_idx_q + OW'(1);
                    state_d  = S_DRIVE;
                end else begin
                    op_idx_d = '0;
                    lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
                    if (vec_idx_q < VEC_LAST) begin
                        vec_idx_d = vec_idx_q + VW'(1);
                        state_d   = S_DRIVE;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (misr_d == exp_sig_q);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Operands follow the LFSR/opcode values that will be live during DRIVE/CAPTURE;
        // they hold through CAPTURE and are zeroed whenever the ALU is not under test.
        if (state_d == S_DRIVE) begin
            alu_op1_d     = lfsr_d;
            alu_op2_d     = {lfsr_d[15:0], lfsr_d[31:16]};
            alu_sft_amt_d = lfsr_d[4:0];
            alu_con_d     = 3'(op_idx_d);
        end else if (state_d != S_CAPTURE) begin
            alu_op1_d     = 32'h0;
            alu_op2_d     = 32'h0;
            alu_sft_amt_d = 5'h0;
            alu_con_d     = 3'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            lfsr_q        <= 32'h0;
            misr_q        <= 32'h0;
            op_idx_q      <= '0;
            vec_idx_q     <= '0;
            exp_sig_q     <= 32'h0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            alu_con_q     <= 3'h0;
            alu_op1_q     <= 32'h0;
            alu_op2_q     <= 32'h0;
            alu_sft_amt_q <= 5'h0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            misr_q        <= misr_d;
            op_idx_q      <= op_idx_d;
            vec_idx_q     <= vec_idx_d;
            exp_sig_q     <= exp_sig_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            alu_con_q     <= alu_con_d;
            alu_op1_q     <= alu_op1_d;
            alu_op2_q     <= alu_op2_d;
            alu_sft_amt_q <= alu_sft_amt_d;
        end
    end

    assign alu_con     = alu_con_q;
    assign alu_op1     = alu_op1_q;
    assign alu_op2     = alu_op2_q;
    assign alu_sft_amt = alu_sft_amt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign signature   = misr_q;

endmodule
